// File: rtl/kernel_streamer.sv
// kernel_streamer
//   Read-side partner of the kernel memory. When a replay is requested and the
//   memory reports ready, the flattened N = KERNEL_SIZE*KERNEL_SIZE coefficient
//   bus is captured into a private snapshot. The coefficients are then replayed
//   one per transfer over a valid/ready stream, first-written word first.
//
// Optional feature (macro KERNEL_STREAMER_REPEAT_EN):
//   Adds input repeat_mode. While it is high on the final transfer, the replay
//   wraps back to index 0 with no bubble, reusing the same snapshot.
//   The spec's port name, "repeat", is a reserved word, hence repeat_mode.
//
// Ports
//   clk           in   1        clock, all state on the rising edge
//   reset_n       in   1        asynchronous active-low reset
//   kernel_ready  in   1        kernel memory holds N valid words
//   kernel_flat   in   N*BITS   word k (k-th written) = [N*BITS-1-k*BITS -: BITS]
//   start         in   1        request one replay (ignored unless idle)
//   repeat_mode   in   1        (KERNEL_STREAMER_REPEAT_EN only) wrap on last word
//   coef_out      out  BITS     current coefficient
//   coef_valid    out  1        coef_out valid
//   coef_ready    in   1        downstream accepts
//   coef_idx      out  IDX_W    index of coef_out
//   coef_last     out  1        final coefficient of the kernel
//   busy          out  1        waiting for the memory or streaming
//   done          out  1        one-cycle pulse after the final transfer
module kernel_streamer #(
  parameter int BITS        = 9,
  parameter int KERNEL_SIZE = 3,
  localparam int N          = KERNEL_SIZE * KERNEL_SIZE,
  localparam int IDX_W      = (N > 1) ? $clog2(N) : 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                kernel_ready,
  input  logic [N*BITS-1:0]   kernel_flat,
  input  logic                start,
`ifdef KERNEL_STREAMER_REPEAT_EN
  input  logic                repeat_mode,
`endif
  output logic [BITS-1:0]     coef_out,
  output logic                coef_valid,
  input  logic                coef_ready,
  output logic [IDX_W-1:0]    coef_idx,
  output logic                coef_last,
  output logic                busy,
  output logic                done
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    WAIT   = 2'b01,
    STREAM = 2'b10,
    DONE   = 2'b11
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  state_t              state;
  state_t              state_nxt;
  logic [IDX_W-1:0]    idx;
  logic [IDX_W-1:0]    idx_nxt;
  logic                load;
  logic [N*BITS-1:0]   snap;
  logic [N*BITS-1:0]   snap_nxt;
  logic                streaming_nxt;

  // Pure word selection from a flattened kernel; word 0 sits in the MSBs.
  function automatic logic [BITS-1:0] pick_word(
    input logic [N*BITS-1:0] flat,
    input logic [IDX_W-1:0]  k
  );
    logic [BITS-1:0] w;
    w = '0;
    for (int i = 0; i < N; i++) begin
      if (k == IDX_W'(i)) begin
        w = flat[N*BITS-1-i*BITS -: BITS];
      end
    end
    return w;
  endfunction

  // Next-state, next-index and snapshot-load decision.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    load      = 1'b0;
    case (state)
      IDLE: begin
        if (start && kernel_ready) begin
          state_nxt = STREAM;
          idx_nxt   = '0;
          load      = 1'b1;
        end else if (start) begin
          state_nxt = WAIT;
        end else begin
          state_nxt = IDLE;
        end
      end
      WAIT: begin
        // start is deliberately not looked at here: no queuing of requests
        if (kernel_ready) begin
          state_nxt = STREAM;
          idx_nxt   = '0;
          load      = 1'b1;
        end else begin
          state_nxt = WAIT;
        end
      end
      STREAM: begin
        // coef_valid is high for the whole of STREAM, so coef_ready alone
        // marks a transfer
        if (coef_ready) begin
          if (idx == LAST_IDX) begin
`ifdef KERNEL_STREAMER_REPEAT_EN
            if (repeat_mode) begin
              state_nxt = STREAM;
              idx_nxt   = '0;
            end else begin
              state_nxt = DONE;
              idx_nxt   = '0;
            end
`else
            state_nxt = DONE;
            idx_nxt   = '0;
`endif
          end else begin
            idx_nxt = idx + IDX_W'(1);
          end
        end else begin
          state_nxt = STREAM;
        end
      end
      DONE: begin
        state_nxt = IDLE;
        idx_nxt   = '0;
      end
      default: begin
        state_nxt = IDLE;
        idx_nxt   = '0;
      end
    endcase
  end

  // Snapshot mux and stream flag feeding the registered outputs.
  always_comb begin
    snap_nxt      = snap;
    streaming_nxt = (state_nxt == STREAM);
    if (load) begin
      snap_nxt = kernel_flat;
    end else begin
      snap_nxt = snap;
    end
  end

  // State, index and snapshot registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      idx   <= '0;
      snap  <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      snap  <= snap_nxt;
    end
  end

  // Registered outputs, computed from the next state so they line up with it.
  // During a stall idx and snap hold, so the payload holds too.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      coef_out   <= '0;
      coef_valid <= 1'b0;
      coef_idx   <= '0;
      coef_last  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      coef_valid <= streaming_nxt;
      coef_out   <= streaming_nxt ? pick_word(snap_nxt, idx_nxt) : '0;
      coef_idx   <= streaming_nxt ? idx_nxt : '0;
      coef_last  <= streaming_nxt && (idx_nxt == LAST_IDX);
      busy       <= (state_nxt == WAIT) || (state_nxt == STREAM);
      done       <= (state_nxt == DONE);
    end
  end

endmodule

// File: tb/tb_kernel_streamer.sv
// tb_kernel_streamer
//   Scoreboard bench for kernel_streamer (BITS=9, KERNEL_SIZE=3). Stimulus pushes
//   the expected coefficient sequence into a queue; a monitor on the falling edge
//   pops and compares on every transfer and checks done timing.
//   Define KERNEL_STREAMER_REPEAT_EN to exercise the repeat feature.
module tb_kernel_streamer;

  localparam int BITS = 9;
  localparam int K    = 3;
  localparam int N    = K * K;
  localparam int IW   = 4;

  typedef struct {
    logic [BITS-1:0] c;
    logic [IW-1:0]   i;
    logic            l;
  } exp_t;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              kernel_ready = 1'b0;
  logic [N*BITS-1:0] kernel_flat = '0;
  logic              start = 1'b0;
  logic              rep_mode = 1'b0;
  logic [BITS-1:0]   coef_out;
  logic              coef_valid;
  logic              coef_ready = 1'b0;
  logic [IW-1:0]     coef_idx;
  logic              coef_last;
  logic              busy;
  logic              done;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   done_cnt = 0;
  int   xfer_cnt = 0;
  int   run_len = 0;
  int   best_run = 0;
  logic pend_done = 1'b0;

  kernel_streamer #(.BITS(BITS), .KERNEL_SIZE(K)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .kernel_ready (kernel_ready),
    .kernel_flat  (kernel_flat),
    .start        (start),
`ifdef KERNEL_STREAMER_REPEAT_EN
    .repeat_mode  (rep_mode),
`endif
    .coef_out     (coef_out),
    .coef_valid   (coef_valid),
    .coef_ready   (coef_ready),
    .coef_idx     (coef_idx),
    .coef_last    (coef_last),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Memory contents 1..9, word 0 = 1 in the MSBs.
  task automatic fill_ramp();
    for (int k = 0; k < N; k++) kernel_flat[N*BITS-1-k*BITS -: BITS] = BITS'(k + 1);
  endtask

  task automatic push_seq();
    for (int k = 0; k < N; k++) q.push_back('{BITS'(k + 1), IW'(k), (k == N - 1)});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_empty(input string name);
    int c;
    c = 0;
    while (q.size() != 0 && c < 200) begin
      tick();
      c++;
    end
    if (q.size() != 0) begin
      chk({name, "_timeout"}, 32'(q.size()), 32'd0);
      q.delete();
    end
  endtask

  // Monitor: scoreboard compare on transfers, done timing and exclusivity.
  always @(negedge clk) begin
    exp_t e;
    logic xfer;
    if (!reset_n) begin
      pend_done = 1'b0;
      run_len   = 0;
    end else begin
      if (done || pend_done) chk("done_timing", 32'(done), 32'(pend_done));
      if (done) begin
        done_cnt++;
        chk("done_busy_excl", 32'(busy), 32'd0);
      end
      xfer      = coef_valid && coef_ready;
      pend_done = 1'b0;
      if (xfer) begin
        xfer_cnt++;
        run_len++;
        if (run_len > best_run) best_run = run_len;
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_xfer: got coef %0h idx %0d expected no transfer", coef_out, coef_idx);
        end else begin
          e = q.pop_front();
          chk("coef_out", 32'(coef_out), 32'(e.c));
          chk("coef_idx", 32'(coef_idx), 32'(e.i));
          chk("coef_last", 32'(coef_last), 32'(e.l));
          pend_done = e.l && !rep_mode;
        end
      end else begin
        run_len = 0;
      end
    end
  end

  initial begin
    int d0;
    int x0;
    int c;

    // Reset state
    #12;
    chk("rst_valid", 32'(coef_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    reset_n = 1'b1;
    tick();

    // Normal replay
    fill_ramp();
    kernel_ready = 1'b1;
    coef_ready   = 1'b1;
    best_run     = 0;
    d0 = done_cnt;
    push_seq();
    pulse_start();
    chk("lat_valid", 32'(coef_valid), 32'd1);
    chk("lat_idx", 32'(coef_idx), 32'd0);
    chk("lat_busy", 32'(busy), 32'd1);
    wait_empty("normal");
    repeat (3) tick();
    chk("normal_zero_stall", 32'(best_run), 32'd9);
    chk("normal_done_cnt", 32'(done_cnt - d0), 32'd1);
    chk("normal_idle_busy", 32'(busy), 32'd0);

    // Backpressure at idx 4
    push_seq();
    pulse_start();
    c = 0;
    while (!(coef_valid && coef_idx == 4'd4) && c < 20) begin
      tick();
      c++;
    end
    coef_ready = 1'b0;
    for (int s = 0; s < 3; s++) begin
      tick();
      chk("bp_coef", 32'(coef_out), 32'd5);
      chk("bp_idx", 32'(coef_idx), 32'd4);
      chk("bp_valid", 32'(coef_valid), 32'd1);
    end
    coef_ready = 1'b1;
    tick();
    chk("bp_resume", 32'(coef_out), 32'd6);
    wait_empty("bp");
    repeat (3) tick();

    // Wait for memory, then snapshot isolation
    kernel_ready = 1'b0;
    push_seq();
    pulse_start();
    chk("wait_busy", 32'(busy), 32'd1);
    chk("wait_valid", 32'(coef_valid), 32'd0);
    repeat (3) tick();
    chk("wait_hold_valid", 32'(coef_valid), 32'd0);
    kernel_ready = 1'b1;
    tick();
    chk("wait_go_valid", 32'(coef_valid), 32'd1);
    tick();
    kernel_flat  = {N{9'h1FF}};
    kernel_ready = 1'b0;
    wait_empty("iso");
    repeat (3) tick();

    // Ignored start during STREAM and DONE
    fill_ramp();
    kernel_ready = 1'b1;
    d0 = done_cnt;
    x0 = xfer_cnt;
    push_seq();
    pulse_start();
    tick();
    tick();
    pulse_start();
    c = 0;
    while (!done && c < 30) begin
      tick();
      c++;
    end
    pulse_start();
    repeat (8) tick();
    chk("ign_xfers", 32'(xfer_cnt - x0), 32'd9);
    chk("ign_done_cnt", 32'(done_cnt - d0), 32'd1);
    chk("ign_idle_valid", 32'(coef_valid), 32'd0);
    chk("ign_queue", 32'(q.size()), 32'd0);
    q.delete();

`ifdef KERNEL_STREAMER_REPEAT_EN
    // Repeat: 1..9,1..9 back to back, done only after the second pass
    rep_mode = 1'b1;
    best_run = 0;
    d0 = done_cnt;
    x0 = xfer_cnt;
    push_seq();
    push_seq();
    pulse_start();
    c = 0;
    while ((xfer_cnt - x0) < 14 && c < 40) begin
      tick();
      c++;
    end
    rep_mode = 1'b0;
    wait_empty("rep");
    repeat (3) tick();
    chk("rep_run", 32'(best_run), 32'd18);
    chk("rep_done_cnt", 32'(done_cnt - d0), 32'd1);
`endif

    // Reset mid-stream aborts immediately
    d0 = done_cnt;
    push_seq();
    pulse_start();
    tick();
    tick();
    reset_n = 1'b0;
    #1;
    chk("arst_valid", 32'(coef_valid), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    chk("arst_coef", 32'(coef_out), 32'd0);
    chk("arst_idx", 32'(coef_idx), 32'd0);
    q.delete();
    tick();
    reset_n = 1'b1;
    repeat (4) tick();
    chk("arst_no_done", 32'(done_cnt - d0), 32'd0);
    chk("arst_idle_valid", 32'(coef_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
